// File: rtl/fir_seq_ctrl_if.sv
// Signal bundle between the FIR band sequencing controller and the parts
// around it: the I2S slave (sample strobe), the dual-port circular sample
// queue, the coefficient ROM and the MAC.
//
// Handshake: wrt_smpl is a one-cycle strobe with no back-pressure. Every
// strobe is written to the queue. A pass request that cannot be served is
// folded into one pending pass, and the loss is flagged on overrun. All
// controller outputs are single-cycle strobes, level enables, or addresses
// that are valid only while their qualifier is high: wr_en for wr_addr, and
// sequencing for rd_addr and coeff_addr.
interface fir_seq_ctrl_if #(
  parameter int AW = 11,
  parameter int CW = 10
);
  logic          wrt_smpl;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] coeff_addr;
  logic          sequencing;
  logic          accum_clr;
  logic          accum_en;
  logic          out_vld;
  logic          busy;
  logic          overrun;
  logic [2:0]    state_dbg;

  // Controller side
  modport master (
    input  wrt_smpl,
    output wr_en, wr_addr, rd_addr, coeff_addr, sequencing,
    output accum_clr, accum_en, out_vld, busy, overrun, state_dbg
  );

  // Source / datapath side
  modport slave (
    output wrt_smpl,
    input  wr_en, wr_addr, rd_addr, coeff_addr, sequencing,
    input  accum_clr, accum_en, out_vld, busy, overrun, state_dbg
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for one FIR band path. The controller writes every
// incoming sample into a circular queue. Once TAPS samples are present, each
// new sample launches a convolution pass over the newest TAPS samples, oldest
// first. A pass runs as CLR -> RUN (TAPS cycles) -> DRAIN -> DONE.
// A request that arrives while a pass is in flight is held as one pending
// pass. That pass reads whatever window is newest when it starts.
module fir_seq_ctrl #(
  parameter int DEPTH = 1536,
  parameter int TAPS  = 1021,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(TAPS)
) (
  input  logic           clk,
  input  logic           rst,
  fir_seq_ctrl_if.master bus
);

  // fill counts up to TAPS inclusive, so it needs one more code than CW
  localparam int FW = $clog2(TAPS + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(TAPS);
  localparam logic [AW-1:0] DEPTH_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] TAPS_M1    = AW'(TAPS - 1);
  localparam logic [AW-1:0] WRAP_ADJ   = AW'(DEPTH - TAPS + 1);
  localparam logic [CW-1:0] K_LAST     = CW'(TAPS - 1);

  // The window must fit in the queue, and a pass needs at least two taps
  generate
    if (TAPS > DEPTH) begin : g_taps_gt_depth
      $error("fir_seq_ctrl: TAPS must not exceed DEPTH");
    end
    if (TAPS < 2) begin : g_taps_too_small
      $error("fir_seq_ctrl: TAPS must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] new_ptr_q;
  logic [AW-1:0] wr_addr_q;
  logic          wr_en_q;
  logic [FW-1:0] fill_q;
  logic          pending_q;
  logic          overrun_q;
  logic          accum_en_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] k_q;

  logic          launch;
  logic          load_win;
  logic          sequencing;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] base_addr;

  // A write that brings (or keeps) the queue full requests a pass.
  // fill_q has already absorbed this write.
  assign launch = wr_en_q && (fill_q == FILL_FULL);

  // The window ends at the most recently written slot, which sits one behind
  // new_ptr. The window start is found by stepping back TAPS-1 with wrap.
  assign last_addr = (new_ptr_q == '0) ? DEPTH_LAST : (new_ptr_q - AW'(1));
  assign base_addr = (last_addr >= TAPS_M1) ? (last_addr - TAPS_M1)
                                            : (last_addr + WRAP_ADJ);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. load_win marks every entry into CLR.
  always_comb begin
    state_d  = state_q;
    load_win = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d  = S_CLR;
          load_win = 1'b1;
        end
      end
      S_CLR: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // A request landing on DONE itself is served just like a pending one
        if (pending_q || launch) begin
          state_d  = S_CLR;
          load_win = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Write path: register the strobe into a queue write and advance the pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      new_ptr_q <= '0;
      fill_q    <= '0;
    end else begin
      wr_en_q <= bus.wrt_smpl;
      if (bus.wrt_smpl) begin
        wr_addr_q <= new_ptr_q;
        new_ptr_q <= (new_ptr_q == DEPTH_LAST) ? '0 : (new_ptr_q + AW'(1));
        if (fill_q != FILL_FULL) begin
          fill_q <= fill_q + FW'(1);
        end
      end
    end
  end

  // Request bookkeeping: hold at most one pending pass and flag any extra one
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == S_DONE) begin
        pending_q <= 1'b0;
      end else if (launch && (state_q != S_IDLE)) begin
        pending_q <= 1'b1;
      end
      if (launch && (state_q != S_IDLE) && pending_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Pass addressing: latch the window base on CLR entry, then walk it in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      k_q      <= '0;
    end else if (load_win) begin
      rd_ptr_q <= base_addr;
      k_q      <= '0;
    end else if (state_q == S_RUN) begin
      rd_ptr_q <= (rd_ptr_q == DEPTH_LAST) ? '0 : (rd_ptr_q + AW'(1));
      if (k_q != K_LAST) begin
        k_q <= k_q + CW'(1);
      end
    end
  end

  // Accumulate enable trails the read phase by the queue/ROM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      accum_en_q <= 1'b0;
    end else begin
      accum_en_q <= sequencing;
    end
  end

  assign sequencing     = (state_q == S_RUN);

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.sequencing = sequencing;
  assign bus.rd_addr    = sequencing ? rd_ptr_q : '0;
  assign bus.coeff_addr = sequencing ? k_q : '0;
  assign bus.accum_clr  = (state_q == S_CLR);
  assign bus.accum_en   = accum_en_q;
  assign bus.out_vld    = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.overrun    = overrun_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl with TAPS=4 and DEPTH=6.
// A schedule-based reference model checks the DUT on every cycle. In addition,
// a vector table covers the first pass, and hand-written sequences cover
// wrap-around, pending passes, overrun and reset in mid-pass.
module tb_fir_seq_ctrl;
  localparam int DEPTH = 6;
  localparam int TAPS  = 4;
  localparam int AW    = 3;
  localparam int CW    = 2;
  localparam int MAXC  = 4096;

  typedef struct packed {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] coeff_addr;
    logic          seq;
    logic          clr;
    logic          en;
    logic          vld;
    logic          busy;
    logic          ovr;
  } obs_t;

  typedef struct {
    int   off;
    obs_t exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.AW(AW), .CW(CW)) bus ();

  fir_seq_ctrl #(.DEPTH(DEPTH), .TAPS(TAPS), .AW(AW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int   total;
  int   bad;
  int   cyc;
  obs_t hist [MAXC];
  vec_t fill_tab [10];
  int   t, t2, t3, n;

  // reference model: passes are tracked as start times, and windows as write counts
  int m_wcount, m_fill, m_pass_s, m_pass_end, m_next_s, m_next_wc, m_win_wc;
  bit m_pending, m_ovr;

  function automatic obs_t mk(bit we, int wa, int ra, int ca, bit sq, bit cl,
                              bit en, bit vl, bit bz, bit ov);
    obs_t o;
    o.wr_en      = we;
    o.wr_addr    = AW'(wa);
    o.rd_addr    = AW'(ra);
    o.coeff_addr = CW'(ca);
    o.seq        = sq;
    o.clr        = cl;
    o.en         = en;
    o.vld        = vl;
    o.busy       = bz;
    o.ovr        = ov;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.wr_en      = bus.wr_en;
    o.wr_addr    = bus.wr_addr;
    o.rd_addr    = bus.rd_addr;
    o.coeff_addr = bus.coeff_addr;
    o.seq        = bus.sequencing;
    o.clr        = bus.accum_clr;
    o.en         = bus.accum_en;
    o.vld        = bus.out_vld;
    o.busy       = bus.busy;
    o.ovr        = bus.overrun;
    return o;
  endfunction

  // wr_addr carries meaning only together with wr_en
  function automatic bit obs_eq(obs_t a, obs_t e);
    if (!e.wr_en) begin
      a.wr_addr = '0;
      e.wr_addr = '0;
    end
    return (a === e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input int c, input obs_t e);
    total++;
    if (!obs_eq(hist[c], e)) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, c, hist[c], e);
    end
  endtask

  // Expected outputs for cycle c, given the inputs (pr, ps) of cycle c-1
  task automatic model_step(input bit pr, input bit ps, input int c, output obs_t e);
    bit launch, active;
    int off;
    e = '0;
    if (pr) begin
      m_wcount = 0; m_fill = 0; m_pending = 0; m_ovr = 0;
      m_pass_s = -100; m_pass_end = -100; m_next_s = -1;
      return;
    end
    if (ps) begin
      e.wr_en   = 1'b1;
      e.wr_addr = AW'(m_wcount % DEPTH);
      m_wcount++;
      if (m_fill < TAPS) m_fill++;
    end
    if (m_next_s == c) begin
      m_pass_s   = c;
      m_pass_end = c + TAPS + 2;
      m_win_wc   = m_next_wc;
      m_next_s   = -1;
    end
    active = (c >= m_pass_s) && (c <= m_pass_end);
    if (active) begin
      off    = c - m_pass_s;
      e.busy = 1'b1;
      e.clr  = (off == 0);
      e.seq  = (off >= 1) && (off <= TAPS);
      if (e.seq) begin
        e.rd_addr    = AW'((m_win_wc - TAPS + off - 1) % DEPTH);
        e.coeff_addr = CW'(off - 1);
      end
      e.en  = (off >= 2) && (off <= TAPS + 1);
      e.vld = (off == TAPS + 2);
    end
    e.ovr  = m_ovr;
    launch = ps && (m_fill == TAPS);
    if (active && c == m_pass_end) begin
      if (launch || m_pending) begin
        m_next_s  = c + 1;
        m_next_wc = m_wcount;
      end
      if (launch && m_pending) m_ovr = 1;
      m_pending = 0;
    end else if (active) begin
      if (launch) begin
        if (m_pending) m_ovr = 1;
        m_pending = 1;
      end
    end else if (launch) begin
      m_next_s  = c + 1;
      m_next_wc = m_wcount;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit s);
    obs_t e, a;
    rst          = r;
    bus.wrt_smpl = s;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    model_step(r, s, cyc, e);
    a         = sample();
    hist[cyc] = a;
    total++;
    if (!obs_eq(a, e)) begin
      bad++;
      $display("FAIL model cyc=%0d: got %h expected %h", cyc, a, e);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0);
  endtask

  task automatic strobe(output int ts);
    ts = cyc;
    step(1'b0, 1'b1);
  endtask

  function automatic int count_vld(input int a, input int b);
    int k = 0;
    for (int c = a; c <= b; c++) if (hist[c].vld) k++;
    return k;
  endfunction

  function automatic int count_busy(input int a, input int b);
    int k = 0;
    for (int c = a; c <= b; c++) if (hist[c].busy || hist[c].seq) k++;
    return k;
  endfunction

  // ---------------- test ----------------
  initial begin
    // first pass, relative to the 4th strobe at t
    fill_tab[0] = '{0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    fill_tab[1] = '{1, mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0)};
    fill_tab[2] = '{2, mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
    fill_tab[3] = '{3, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0)};
    fill_tab[4] = '{4, mk(0, 0, 1, 1, 1, 0, 1, 0, 1, 0)};
    fill_tab[5] = '{5, mk(0, 0, 2, 2, 1, 0, 1, 0, 1, 0)};
    fill_tab[6] = '{6, mk(0, 0, 3, 3, 1, 0, 1, 0, 1, 0)};
    fill_tab[7] = '{7, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0)};
    fill_tab[8] = '{8, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)};
    fill_tab[9] = '{9, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; bus.wrt_smpl = 1'b0;

    // reset with random strobes
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
    chk("reset_outputs", int'(hist[cyc]), 0);
    chk("reset_state_dbg", int'(bus.state_dbg), 0);

    // fill: three samples, no pass yet
    t3 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      strobe(t); idle(19);
      chk("fill_wr_en", int'(hist[t + 1].wr_en), 1);
      chk("fill_wr_addr", int'(hist[t + 1].wr_addr), i);
    end
    chk("fill_no_pass", count_busy(t3, cyc), 0);
    strobe(t); idle(14);
    for (int i = 0; i < 10; i++) chk_obs("fill_tab", t + fill_tab[i].off, fill_tab[i].exp);

    // wrap: write addresses 4,5,0; the window after the 7th sample is 3,4,5,0
    for (int i = 0; i < 3; i++) begin
      strobe(t); idle(19);
      chk("wrap_wr_addr", int'(hist[t + 1].wr_addr), (4 + i) % DEPTH);
    end
    for (int k = 0; k < 4; k++) chk("wrap_rd_addr", int'(hist[t + 3 + k].rd_addr), (3 + k) % DEPTH);

    // pending: a second strobe during RUN queues exactly one follow-on pass
    strobe(t); idle(3); strobe(t2); idle(25);
    chk("pend_strobe_time", t2 - t, 4);
    chk("pend_wr_en", int'(hist[t + 5].wr_en), 1);
    chk("pend_vld1", int'(hist[t + 8].vld), 1);
    chk("pend_clr2", int'(hist[t + 9].clr), 1);
    chk("pend_vld2", int'(hist[t + 15].vld), 1);
    chk("pend_no_ovr", int'(hist[t + 16].ovr), 0);
    for (int k = 0; k < 4; k++) chk("pend_rd_addr", int'(hist[t + 10 + k].rd_addr), (5 + k) % DEPTH);

    // overrun: two strobes during one RUN
    strobe(t); idle(2); strobe(t2); idle(1); strobe(t3); idle(30);
    chk("ovr_before", int'(hist[t + 6].ovr), 0);
    chk("ovr_set", int'(hist[t + 7].ovr), 1);
    chk("ovr_sticky", int'(hist[t + 35].ovr), 1);
    chk("ovr_pass_count", count_vld(t + 1, t + 35), 2);
    for (int k = 0; k < 4; k++) chk("ovr_rd_addr", int'(hist[t + 10 + k].rd_addr), (2 + k) % DEPTH);

    // reset in mid-pass: the pass aborts and the queue must refill
    strobe(t); idle(4); step(1'b1, 1'b0); idle(20);
    chk("rst_mid_outputs", int'(hist[t + 6]), 0);
    chk("rst_mid_no_vld", count_vld(t + 6, t + 25), 0);
    t3 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      strobe(t); idle(19);
    end
    chk("rst_refill_no_pass", count_busy(t3, cyc), 0);
    strobe(t); idle(12);
    chk("rst_refill_clr", int'(hist[t + 2].clr), 1);
    for (int k = 0; k < 4; k++) chk("rst_refill_rd_addr", int'(hist[t + 3 + k].rd_addr), k);

    // random traffic with varying sample density and occasional reset
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    for (int ph = 0; ph < 8; ph++) begin
      int gap;
      gap = $urandom_range(1, 12);
      for (int i = 0; i < 180; i++) begin
        bit r, s;
        r = ($urandom_range(0, 299) == 0);
        s = ($urandom_range(0, gap - 1) == 0);
        step(r, s);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
